fx_sm_seq_divider: RTL and testbench



---
 rtl/fx_div_pkg.sv | 24 ++
 rtl/fx_div_step.sv | 38 +++
 rtl/fx_sm_seq_divider.sv | 168 ++++++++++++++++
 tb/tb_fx_sm_seq_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fx_div_pkg.sv
`default_nettype none
// ============================================================================
// Module : fx_div_pkg
// Brief  : Shared widths, sign-bit indices and FSM encoding for the SM divider
// Rev    : 1.0  initial release
// ============================================================================
package fx_div_pkg;

    localparam int c_QW     = 10;
    localparam int c_MW     = c_QW - 1;
    localparam int c_DW     = 2 * c_QW - 1;

    // Sign-bit positions shared with the FIR adder/multiplier wrappers
    localparam int c_Q_SIGN = c_QW - 1;
    localparam int c_D_SIGN = c_DW - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/fx_div_step.sv
`default_nettype none
// ============================================================================
// Module : fx_div_step
// Brief  : One restoring-division step: compare-and-conditional-subtract
// Rev    : 1.0  initial release
// ============================================================================
module fx_div_step
    import fx_div_pkg::*;
#(
    parameter int W = c_MW + 1
) (
    input  logic [W-1:0] i_t,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_r,
    output logic         o_q
);

    logic [W:0]   w_c;
    logic [W-1:0] w_nd;
    logic [W-1:0] w_diff;

    // t - d as t + ~d + 1; the final carry is set exactly when t >= d
    assign w_c[0] = 1'b1;
    assign w_nd   = ~i_d;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_fa
            assign w_diff[gi]  = i_t[gi] ^ w_nd[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (i_t[gi] & w_nd[gi]) | (w_c[gi] & (i_t[gi] ^ w_nd[gi]));
        end
    endgenerate

    assign o_q = w_c[W];
    assign o_r = o_q ? w_diff : i_t;

endmodule
`default_nettype wire

// File: rtl/fx_sm_seq_divider.sv
`default_nettype none
// ============================================================================
// Module : fx_sm_seq_divider
// Brief  : Sequential restoring sign-magnitude divider, 19b / 10b -> 10b q, 9b r
// Rev    : 1.0  initial release
// ============================================================================
module fx_sm_seq_divider
    import fx_div_pkg::*;
#(
    parameter int QW = c_QW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*QW-2:0] dividend,
    input  logic [QW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [QW-1:0]   quotient,
    output logic [QW-2:0]   remainder,
    output logic            ovf,
    output logic            dbz
);

    localparam int MW = QW - 1;
    localparam int DW = 2 * QW - 1;
    localparam int CW = $clog2(MW);

    div_state_t    r_state;
    div_state_t    w_state_nxt;

    logic [MW-1:0] r_dvd_lo;
    logic [MW-1:0] r_dsr;
    logic [MW-1:0] r_rem;
    logic [MW-1:0] r_q;
    logic [CW-1:0] r_cnt;
    logic          r_qsign;
    logic          r_sat;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [QW-1:0] r_quotient;
    logic [MW-1:0] r_remainder;
    logic          r_ovf;
    logic          r_dbz;

    logic [MW-1:0] w_dsr_mag;
    logic [MW-1:0] w_dvd_hi;
    logic          w_dbz;
    logic          w_ovf;
    logic [MW:0]   w_t;
    logic [MW:0]   w_r_nxt;
    logic          w_q_bit;
    logic [MW-1:0] w_q_fin;
    logic [MW-1:0] w_q_res;
    logic          w_accept;
    logic          w_done_ld;

    assign w_dsr_mag = divisor[MW-1:0];
    assign w_dvd_hi  = dividend[DW-2:MW];
    assign w_dbz     = (w_dsr_mag == '0);
    assign w_ovf     = !w_dbz && (w_dvd_hi >= w_dsr_mag);

    // Shift the next dividend bit (MSB first) into the partial remainder
    assign w_t = (MW + 1)'({r_rem, r_dvd_lo[r_cnt]});

    fx_div_step #(
        .W   (MW + 1)
    ) u_step (
        .i_t (w_t),
        .i_d ({1'b0, r_dsr}),
        .o_r (w_r_nxt),
        .o_q (w_q_bit)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_ld   = 1'b0;
        w_q_fin     = r_q;
        w_q_fin[r_cnt] = w_q_bit;
        w_q_res     = r_sat ? '1 : w_q_fin;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_done_ld   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Saturating cases pass through a single CALC cycle (counter preset to 0),
    // giving them a fixed one-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dvd_lo    <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_qsign     <= 1'b0;
            r_sat       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);

            if (w_accept) begin
                r_dvd_lo <= dividend[MW-1:0];
                r_dsr    <= w_dsr_mag;
                r_qsign  <= dividend[DW-1] ^ divisor[QW-1];
                r_dbz    <= w_dbz;
                r_ovf    <= w_ovf;
                r_sat    <= w_dbz | w_ovf;
                r_q      <= '0;
                if (w_dbz || w_ovf) begin
                    r_rem <= '0;
                    r_cnt <= '0;
                end else begin
                    r_rem <= w_dvd_hi;
                    r_cnt <= CW'(MW - 1);
                end
            end

            if ((r_state == CALC) && !r_sat) begin
                r_rem        <= w_r_nxt[MW-1:0];
                r_q[r_cnt]   <= w_q_bit;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end

            if (w_done_ld) begin
                r_quotient  <= {r_qsign & (|w_q_res), w_q_res};
                r_remainder <= r_sat ? '0 : w_r_nxt[MW-1:0];
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_fx_sm_seq_divider.sv
`default_nettype none
// ============================================================================
// Module : tb_fx_sm_seq_divider
// Brief  : Directed self-checking bench for fx_sm_seq_divider
// Rev    : 1.0  initial release
// ============================================================================
module tb_fx_sm_seq_divider;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] dividend;
    logic [9:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  quotient;
    logic [8:0]  remainder;
    logic        ovf;
    logic        dbz;

    int total = 0;
    int bad   = 0;

    fx_sm_seq_divider #(
        .QW        (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".quotient"},  32'(quotient),  32'd0);
        chk({tag, ".remainder"}, 32'(remainder), 32'd0);
        chk({tag, ".ovf"},       32'(ovf),       32'd0);
        chk({tag, ".dbz"},       32'(dbz),       32'd0);
    endtask

    // Accept edge is cycle 0; latency counts edges until out_valid is seen
    task automatic wait_valid(input string tag, input int exp_lat);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic [18:0] dvd, input logic [9:0] dsr,
                          input logic [9:0] eq, input logic [8:0] er,
                          input logic eovf, input logic edbz, input int elat);
        @(negedge clk);
        chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(tag, elat);
        chk({tag, ".quotient"},  32'(quotient),  32'(eq));
        chk({tag, ".remainder"}, 32'(remainder), 32'(er));
        chk({tag, ".ovf"},       32'(ovf),       32'(eovf));
        chk({tag, ".dbz"},       32'(dbz),       32'(edbz));
        @(posedge clk); #1;
        chk({tag, ".out_valid_post"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready_post"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Basic and signed divides
        run_op("p100_7",    {1'b0, 18'd100},  {1'b0, 9'd7},  10'h00E, 9'd2, 1'b0, 1'b0, 9);
        run_op("n1000_25",  {1'b1, 18'd1000}, {1'b0, 9'd25}, 10'h228, 9'd0, 1'b0, 1'b0, 9);
        run_op("n3_7_nozero", {1'b1, 18'd3},  {1'b0, 9'd7},  10'h000, 9'd3, 1'b0, 1'b0, 9);

        // Overflow boundary and divide-by-negative-zero
        run_op("p511_1",    {1'b0, 18'd511},  {1'b0, 9'd1},  10'h1FF, 9'd0, 1'b0, 1'b0, 9);
        run_op("p512_1_ovf", {1'b0, 18'd512}, {1'b0, 9'd1},  10'h1FF, 9'd0, 1'b1, 1'b0, 1);
        run_op("dbz_neg0",  {1'b0, 18'd5},    10'h200,       10'h3FF, 9'd0, 1'b0, 1'b1, 1);

        // Back-pressure: hold the 100/7 result while new operands toggle
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = {1'b0, 18'd100};
        divisor  = {1'b0, 9'd7};
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("bp_first", 9);
        dividend = {1'b0, 18'd1000};
        divisor  = {1'b0, 9'd25};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            @(posedge clk); #1;
            chk("bp_hold.out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold.in_ready",  32'(in_ready),  32'd0);
            chk("bp_hold.quotient",  32'(quotient),  32'h00E);
            chk("bp_hold.remainder", 32'(remainder), 32'd2);
        end
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release.in_ready",  32'(in_ready),  32'd1);
        chk("bp_release.out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept.in_ready", 32'(in_ready), 32'd0);
        wait_valid("bp_second", 9);
        chk("bp_second.quotient",  32'(quotient),  32'h028);
        chk("bp_second.remainder", 32'(remainder), 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the 4th CALC cycle
        @(negedge clk);
        in_valid = 1'b1;
        dividend = {1'b0, 18'd100};
        divisor  = {1'b0, 9'd7};
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mid.in_ready_before", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", {1'b0, 18'd100}, {1'b0, 9'd7}, 10'h00E, 9'd2, 1'b0, 1'b0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
